efuse_pgm_seq: RTL and testbench



---
 rtl/efuse_pkg.sv | 17 +
 rtl/efuse_pgm_seq_if.sv | 30 +++
 rtl/efuse_pgm_seq.sv | 113 +++++++++++
 tb/tb_efuse_pgm_seq.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/efuse_pkg.sv
// Shared eFuse definitions: program-sequencer state encoding and array constants
// common to the sequencer and the write engine.
package efuse_pkg;

    localparam int unsigned EFUSE_BITS = 256;
    localparam int unsigned EFUSE_TCLR = 14;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StIssue,
        StWaitAck,
        StWaitDone,
        StFinish
    } pgm_state_t;

endpackage

// File: rtl/efuse_pgm_seq_if.sv
// Job interface between the program sequencer (master) and the eFuse write engine (slave).
interface efuse_pgm_seq_if #(
    parameter int unsigned NW   = 64,
    parameter int unsigned WSEL = efuse_pkg::EFUSE_BITS / NW
);
    localparam int unsigned SW = (WSEL > 1) ? $clog2(WSEL) : 1;

    logic          wr_start;
    logic [SW-1:0] wr_sel;
    logic [NW-1:0] wr_data;
    logic          wr_busy;
    logic          wr_done;

    modport master (
        output wr_start,
        output wr_sel,
        output wr_data,
        input  wr_busy,
        input  wr_done
    );

    modport slave (
        input  wr_start,
        input  wr_sel,
        input  wr_data,
        output wr_busy,
        output wr_done
    );

endinterface

// File: rtl/efuse_pgm_seq.sv
// eFuse program sequencer: splits a 256-bit image into NW-bit chunks, skips zero chunks and
// runs one write-engine job per remaining chunk under a per-chunk watchdog.
module efuse_pgm_seq
    import efuse_pkg::*;
#(
    parameter int unsigned NW   = 64,
    parameter int unsigned WSEL = EFUSE_BITS / NW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pgm_req,
    input  logic [EFUSE_BITS-1:0] pgm_data,
    input  logic [15:0]           rg_pgm_tmo,
    output logic                  pgm_busy,
    output logic                  pgm_done,
    output logic                  pgm_err,
    efuse_pgm_seq_if.master       wr_if
);
    localparam int unsigned SW = (WSEL > 1) ? $clog2(WSEL) : 1;
    localparam int unsigned IW = SW + 1;

    pgm_state_t            state;
    logic [EFUSE_BITS-1:0] data_q;
    logic [IW-1:0]         idx;
    logic [15:0]           tmo_cnt;
    logic [NW-1:0]         chunk;
    logic                  tmo_hit;
    logic                  last_idx;

    always_comb begin
        chunk    = data_q[NW*int'(idx[SW-1:0]) +: NW];
        last_idx = (idx == IW'(WSEL));
        // Counter was cleared in ISSUE, so the limit expires after exactly rg_pgm_tmo wait cycles
        tmo_hit  = (rg_pgm_tmo != 16'd0) && (tmo_cnt == rg_pgm_tmo - 16'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= StIdle;
            data_q         <= '0;
            idx            <= '0;
            tmo_cnt        <= '0;
            pgm_busy       <= 1'b0;
            pgm_done       <= 1'b0;
            pgm_err        <= 1'b0;
            wr_if.wr_start <= 1'b0;
            wr_if.wr_sel   <= '0;
            wr_if.wr_data  <= '0;
        end else begin
            pgm_done       <= 1'b0;
            wr_if.wr_start <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (pgm_req) begin
                        data_q   <= pgm_data;
                        idx      <= '0;
                        pgm_err  <= 1'b0;
                        pgm_busy <= 1'b1;
                        state    <= StScan;
                    end
                end
                StScan: begin
                    if (last_idx) begin
                        pgm_done <= 1'b1;
                        state    <= StFinish;
                    end else if (chunk == '0) begin
                        idx <= idx + IW'(1);
                    end else if (!wr_if.wr_busy) begin
                        wr_if.wr_sel   <= idx[SW-1:0];
                        wr_if.wr_data  <= chunk;
                        wr_if.wr_start <= 1'b1;
                        state          <= StIssue;
                    end
                end
                StIssue: begin
                    tmo_cnt <= '0;
                    state   <= StWaitAck;
                end
                StWaitAck: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (wr_if.wr_busy) begin
                        state <= StWaitDone;
                    end else if (tmo_hit) begin
                        pgm_err  <= 1'b1;
                        pgm_done <= 1'b1;
                        state    <= StFinish;
                    end
                end
                StWaitDone: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (!wr_if.wr_busy && wr_if.wr_done) begin
                        idx   <= idx + IW'(1);
                        state <= StScan;
                    end else if (tmo_hit) begin
                        // Remaining chunks are abandoned on a hung engine
                        pgm_err  <= 1'b1;
                        pgm_done <= 1'b1;
                        state    <= StFinish;
                    end
                end
                StFinish: begin
                    pgm_busy <= 1'b0;
                    state    <= StIdle;
                end
                default: begin
                    pgm_busy <= 1'b0;
                    state    <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_efuse_pgm_seq.sv
// Bench for efuse_pgm_seq: behavioural write engine, job scoreboard and per-scenario tasks.
module tb_efuse_pgm_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pgm_req = 1'b0;
    logic [255:0] pgm_data = '0;
    logic [15:0]  rg_pgm_tmo = '0;
    logic         pgm_busy;
    logic         pgm_done;
    logic         pgm_err;

    logic eng_busy = 1'b0;
    logic eng_done = 1'b0;
    logic eng_dead = 1'b0;
    logic occ_busy = 1'b0;
    int   eng_cnt = 0;

    efuse_pgm_seq_if bus ();

    assign bus.wr_busy = eng_busy | occ_busy;
    assign bus.wr_done = eng_done;

    efuse_pgm_seq #(.NW(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .pgm_req    (pgm_req),
        .pgm_data   (pgm_data),
        .rg_pgm_tmo (rg_pgm_tmo),
        .pgm_busy   (pgm_busy),
        .pgm_done   (pgm_done),
        .pgm_err    (pgm_err),
        .wr_if      (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine: busy for 3 cycles after a start, then sticky done; a dead engine never responds
    always @(posedge clk) begin
        if (bus.wr_start) begin
            eng_done <= 1'b0;
            if (!eng_dead) begin
                eng_busy <= 1'b1;
                eng_cnt  <= 2;
            end
        end else if (eng_busy) begin
            if (eng_cnt == 0) begin
                eng_busy <= 1'b0;
                eng_done <= 1'b1;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    typedef struct {
        logic [1:0]  sel;
        logic [63:0] data;
        int          c;
    } job_t;

    job_t obs_q[$];
    job_t exp_q[$];
    int   done_q[$];
    logic derr_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always @(negedge clk) begin
        if (bus.wr_start) obs_q.push_back('{sel: bus.wr_sel, data: bus.wr_data, c: cyc});
        if (pgm_done) begin
            done_q.push_back(cyc);
            derr_q.push_back(pgm_err);
        end
    end

    task automatic clear_q;
        obs_q.delete();
        exp_q.delete();
        done_q.delete();
        derr_q.delete();
    endtask

    task automatic push_exp(input logic [255:0] d);
        for (int i = 0; i < 4; i++) begin
            if (d[i*64 +: 64] != 64'd0) exp_q.push_back('{sel: 2'(i), data: d[i*64 +: 64], c: -1});
        end
    endtask

    task automatic send_req(input logic [255:0] d, output int c0);
        @(posedge clk); #1;
        pgm_req  = 1'b1;
        pgm_data = d;
        c0       = cyc;
        @(posedge clk); #1;
        pgm_req  = 1'b0;
        pgm_data = ~d;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (obs_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({pgm_busy, pgm_done, pgm_err, bus.wr_start} !== 4'b0)
            begin n_err++; $display("FAIL reset_flags: got %b want 0000",
                {pgm_busy, pgm_done, pgm_err, bus.wr_start}); end
        n_vec++;
        if (bus.wr_sel !== 2'd0) begin n_err++; $display("FAIL reset_sel: got %h want 0", bus.wr_sel); end
        n_vec++;
        if (bus.wr_data !== 64'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.wr_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({pgm_busy, pgm_done, bus.wr_start} !== 3'b0)
            begin n_err++; $display("FAIL idle_after_reset: got %b want 000",
                {pgm_busy, pgm_done, bus.wr_start}); end
    endtask

    task automatic test_two_chunks;
        logic [255:0] img;
        int c0;
        bit ok;
        job_t e, o;
        img = '0;
        img[63:0]    = 64'h1;
        img[191:128] = 64'h8000_0000_0000_0000;
        rg_pgm_tmo = 16'd200;
        clear_q();
        push_exp(img);
        send_req(img, c0);
        wait_done(100, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL two_done_timeout: got none want pgm_done"); end
        if (ok) begin
            n_vec++;
            if (done_q[0] - c0 != 16) begin n_err++; $display("FAIL two_done_cycle: got %0d want 16", done_q[0] - c0); end
            n_vec++;
            if (derr_q[0] !== 1'b0) begin n_err++; $display("FAIL two_err: got %b want 0", derr_q[0]); end
        end
        if (obs_q.size() == 2) begin
            n_vec++;
            if (obs_q[0].c - c0 != 2) begin n_err++; $display("FAIL two_start0_cycle: got %0d want 2", obs_q[0].c - c0); end
            n_vec++;
            if (obs_q[1].c - c0 != 9) begin n_err++; $display("FAIL two_start1_cycle: got %0d want 9", obs_q[1].c - c0); end
        end
        n_vec++;
        if (obs_q.size() != exp_q.size())
            begin n_err++; $display("FAIL two_job_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_vec++;
            if ({o.sel, o.data} !== {e.sel, e.data})
                begin n_err++; $display("FAIL two_job: got %h/%h want %h/%h", o.sel, o.data, e.sel, e.data); end
        end
    endtask

    task automatic test_all_zero;
        int c0;
        rg_pgm_tmo = 16'd0;
        clear_q();
        send_req('0, c0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_vec++;
            if (pgm_busy !== (i <= 6)) begin n_err++; $display("FAIL zero_busy_c%0d: got %b want %b", i, pgm_busy, (i <= 6)); end
            n_vec++;
            if (pgm_done !== (i == 6)) begin n_err++; $display("FAIL zero_done_c%0d: got %b want %b", i, pgm_done, (i == 6)); end
        end
        n_vec++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL zero_no_start: got %0d want 0", obs_q.size()); end
    endtask

    task automatic test_req_while_busy;
        logic [255:0] img_a, img_b;
        int c0;
        bit ok;
        job_t e, o;
        img_a = '0;
        img_a[127:64]  = 64'hDEAD_BEEF_0000_0001;
        img_a[255:192] = 64'h0123_4567_89AB_CDEF;
        img_b = '0;
        img_b[63:0]    = 64'hFFFF;
        img_b[191:128] = 64'h5555;
        clear_q();
        push_exp(img_a);
        send_req(img_a, c0);
        wait_start(50, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL busy_first_start: got none want wr_start"); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        pgm_req  = 1'b1;
        pgm_data = img_b;
        @(posedge clk); #1;
        pgm_req  = 1'b0;
        wait_done(100, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL busy_done_timeout: got none want pgm_done"); end
        repeat (5) @(negedge clk);
        n_vec++;
        if (pgm_busy !== 1'b0 || done_q.size() != 1)
            begin n_err++; $display("FAIL busy_no_requeue: got busy=%b dones=%0d want 0/1", pgm_busy, done_q.size()); end
        n_vec++;
        if (obs_q.size() != exp_q.size())
            begin n_err++; $display("FAIL busy_job_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_vec++;
            if ({o.sel, o.data} !== {e.sel, e.data})
                begin n_err++; $display("FAIL busy_job: got %h/%h want %h/%h", o.sel, o.data, e.sel, e.data); end
        end
    endtask

    task automatic test_watchdog;
        logic [255:0] img;
        int c0;
        bit ok;
        job_t e, o;
        img = '0;
        img[63:0]   = 64'h5;
        img[127:64] = 64'h7;
        eng_dead   = 1'b1;
        rg_pgm_tmo = 16'd20;
        clear_q();
        send_req(img, c0);
        wait_done(200, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL wdog_done_timeout: got none want pgm_done"); end
        if (ok && obs_q.size() > 0) begin
            n_vec++;
            if (done_q[0] - obs_q[0].c != 21)
                begin n_err++; $display("FAIL wdog_latency: got %0d want 21", done_q[0] - obs_q[0].c); end
            n_vec++;
            if (derr_q[0] !== 1'b1) begin n_err++; $display("FAIL wdog_err_at_done: got %b want 1", derr_q[0]); end
        end
        repeat (10) @(negedge clk);
        n_vec++;
        if (obs_q.size() != 1) begin n_err++; $display("FAIL wdog_start_count: got %0d want 1", obs_q.size()); end
        n_vec++;
        if (pgm_err !== 1'b1) begin n_err++; $display("FAIL wdog_err_sticky: got %b want 1", pgm_err); end

        eng_dead   = 1'b0;
        rg_pgm_tmo = 16'd0;
        img = '0;
        img[191:128] = 64'h42;
        clear_q();
        push_exp(img);
        send_req(img, c0);
        @(negedge clk);
        n_vec++;
        if (pgm_err !== 1'b0) begin n_err++; $display("FAIL wdog_err_clear: got %b want 0", pgm_err); end
        wait_done(100, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL wdog_rerun_timeout: got none want pgm_done"); end
        n_vec++;
        if (obs_q.size() != exp_q.size())
            begin n_err++; $display("FAIL wdog_rerun_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_vec++;
            if ({o.sel, o.data} !== {e.sel, e.data})
                begin n_err++; $display("FAIL wdog_rerun_job: got %h/%h want %h/%h", o.sel, o.data, e.sel, e.data); end
        end
    endtask

    task automatic test_reset_mid;
        logic [255:0] img;
        int c0;
        bit ok;
        job_t e, o;
        img = '0;
        img[255:192] = 64'hA5A5_5A5A_C3C3_3C3C;
        clear_q();
        send_req(img, c0);
        wait_start(50, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL rstmid_start: got none want wr_start"); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_vec++;
            if ({pgm_busy, pgm_done, pgm_err, bus.wr_start} !== 4'b0 || bus.wr_sel !== 2'd0 ||
                bus.wr_data !== 64'd0)
                begin n_err++; $display("FAIL rstmid_outputs_c%0d: got %b/%h/%h want 0/0/0", i,
                    {pgm_busy, pgm_done, pgm_err, bus.wr_start}, bus.wr_sel, bus.wr_data); end
        end
        n_vec++;
        if (done_q.size() != 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d want 0", done_q.size()); end
        repeat (6) @(posedge clk);
        img = '0;
        img[63:0]    = 64'h3;
        img[255:192] = 64'h7;
        clear_q();
        push_exp(img);
        send_req(img, c0);
        wait_done(100, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL rstmid_rerun_timeout: got none want pgm_done"); end
        n_vec++;
        if (obs_q.size() != exp_q.size())
            begin n_err++; $display("FAIL rstmid_job_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_vec++;
            if ({o.sel, o.data} !== {e.sel, e.data})
                begin n_err++; $display("FAIL rstmid_job: got %h/%h want %h/%h", o.sel, o.data, e.sel, e.data); end
        end
    endtask

    task automatic test_engine_occupied;
        logic [255:0] img;
        int c0;
        bit ok;
        job_t e, o;
        img = '0;
        img[127:64] = 64'hF0;
        clear_q();
        push_exp(img);
        @(posedge clk); #1;
        occ_busy = 1'b1;
        pgm_req  = 1'b1;
        pgm_data = img;
        c0       = cyc;
        @(posedge clk); #1;
        pgm_req  = 1'b0;
        pgm_data = '1;
        repeat (9) @(posedge clk);
        #1;
        occ_busy = 1'b0;
        wait_done(100, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL occ_done_timeout: got none want pgm_done"); end
        if (obs_q.size() > 0) begin
            n_vec++;
            if (obs_q[0].c - c0 != 11) begin n_err++; $display("FAIL occ_start_cycle: got %0d want 11", obs_q[0].c - c0); end
        end
        n_vec++;
        if (obs_q.size() != exp_q.size())
            begin n_err++; $display("FAIL occ_job_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_vec++;
            if ({o.sel, o.data} !== {e.sel, e.data})
                begin n_err++; $display("FAIL occ_job: got %h/%h want %h/%h", o.sel, o.data, e.sel, e.data); end
        end
    endtask

    initial begin
        test_reset();
        test_two_chunks();
        test_all_zero();
        test_req_while_busy();
        test_watchdog();
        test_reset_mid();
        test_engine_occupied();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion want $finish");
        $fatal(1, "bench timeout");
    end

endmodule
